fir_seq_ctrl: RTL and testbench
===============================

FIR_SEQ_CTRL -- requirements
Module: fir_seq_ctrl

Interface
REQ-001 SHALL have parameter NTAPS, default 11, number of coefficient entries.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, input sample FIFO depth.
REQ-003 SHALL have parameter TIMEOUT, default 255, maximum WAIT cycles before abort.
REQ-004 ap_clk  in  1  single clock; all logic on rising edge.
REQ-005 ap_rst  in  1  synchronous active-high reset.
REQ-006 s_data / s_valid / s_ready  in/in/out  32/1/1  upstream sample stream.
REQ-007 m_data / m_valid / m_ready  out/out/in  32/1/1  downstream filtered-result stream.
REQ-008 cfg_we / cfg_addr / cfg_data  in/in/in  1/4/32  coefficient write port.
REQ-009 fir_start  out  1  drives FIR ap_start.
REQ-010 fir_x  out  32  drives FIR x.
REQ-011 fir_done / fir_idle  in/in  1/1  from FIR ap_done / ap_idle.
REQ-012 fir_return  in  32  from FIR ap_return.
REQ-013 c_address0 / c_ce0  in/in  4/1  FIR coefficient read request.
REQ-014 c_q0  out  32  coefficient read data to FIR.
REQ-015 busy  out  1  high when FSM not IDLE.
REQ-016 err_timeout  out  1  sticky timeout flag.
REQ-017 sample_count  out  16  completed output handshakes.

Function
REQ-018 Coefficient file: NTAPS x 32 registers; cfg_we=1 with cfg_addr<NTAPS and FSM in IDLE writes cfg_data; all other writes ignored.
REQ-019 Coefficient read: c_ce0=1 at edge t registers coef[c_address0] into c_q0, visible cycle t+1; c_address0>=NTAPS returns 0; c_ce0=0 holds c_q0.
REQ-020 Same-cycle write and read of one address: c_q0 returns the pre-write value.
REQ-021 Sample FIFO: FIFO_DEPTH x 32; s_ready = not full; push on s_valid&s_ready; s_data ignored when s_ready=0.
REQ-022 FSM states IDLE, LAUNCH, WAIT, OUT, one-hot or encoded.
REQ-023 IDLE -> LAUNCH when FIFO non-empty and fir_idle=1; the FIFO head is popped into fir_x on that edge.
REQ-024 LAUNCH: fir_start=1 for exactly one cycle; -> WAIT unconditionally.
REQ-025 fir_x SHALL hold constant from LAUNCH until return to IDLE.
REQ-026 WAIT: on fir_done=1, fir_return captured into m_data; -> OUT.
REQ-027 WAIT: timeout counter cleared on WAIT entry, incremented each WAIT cycle; reaching TIMEOUT without fir_done sets err_timeout, discards sample, -> IDLE.
REQ-028 OUT: m_valid=1, m_data stable; on m_ready=1 -> IDLE, sample_count += 1 (wraps 0xFFFF->0).
REQ-029 fir_done outside WAIT is ignored.
REQ-030 Simultaneous push and pop: both occur, FIFO count unchanged; a push into an empty FIFO is not poppable in the same cycle.
REQ-031 Latency: sample pushed at edge t into empty FIFO, FSM IDLE, fir_idle=1 -> fir_start=1 in cycle t+2.
REQ-032 fir_start=0 in all states except LAUNCH; m_valid=0 in all states except OUT.
REQ-033 err_timeout cleared only by ap_rst.

Reset
REQ-034 ap_rst=1 at an edge SHALL force IDLE, FIFO empty, fir_start=0, m_valid=0, m_data=0, fir_x=0, c_q0=0, err_timeout=0, sample_count=0, timeout counter=0.
REQ-035 Coefficient registers SHALL reset to 0.
REQ-036 Reset asserted mid-WAIT or mid-OUT SHALL abandon the sample; a later fir_done SHALL be ignored.

Verification
REQ-037 Write coef[k]=k+1 for k=0..10, then c_ce0=1, c_address0=3 -> c_q0=4 next cycle; c_address0=12 -> c_q0=0.
REQ-038 Push 5, fir_idle=1, model returns 0x1234 after 60 cycles -> fir_start one-cycle pulse at t+2, fir_x=5 throughout, m_data=0x1234, m_valid=1 until m_ready, sample_count=1.
REQ-039 Hold m_ready=0, push 6 samples -> s_ready drops after FIFO fills (4 queued + 1 in flight); results emerge in push order after release.
REQ-040 fir_done never asserted -> err_timeout=1 after 255 WAIT cycles, FSM IDLE, next sample launches normally.
REQ-041 cfg_we=1 during WAIT with cfg_addr=2, cfg_data=0xFFFF -> coef[2] unchanged.
REQ-042 ap_rst pulsed in WAIT, then fir_done=1 -> no m_valid, all outputs at reset values.

Source files
------------

// File: rtl/fir_seq_ctrl.sv
// Sequences samples from a small FIFO through an external FIR core and hands results downstream.
// Launch two cycles after a push into an idle, empty controller; s_ready drops when the FIFO is full.
module fir_seq_ctrl #(
    parameter int unsigned NTAPS      = 11,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        cfg_we,
    input  logic [3:0]  cfg_addr,
    input  logic [31:0] cfg_data,
    output logic        fir_start,
    output logic [31:0] fir_x,
    input  logic        fir_done,
    input  logic        fir_idle,
    input  logic [31:0] fir_return,
    input  logic [3:0]  c_address0,
    input  logic        c_ce0,
    output logic [31:0] c_q0,
    output logic        busy,
    output logic        err_timeout,
    output logic [15:0] sample_count
);

    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUT    = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fifo_mem_q [FIFO_DEPTH];
    logic [31:0]     fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
    logic [31:0]     coef_q [NTAPS];
    logic [31:0]     coef_d [NTAPS];
    logic [31:0]     c_q0_q, c_q0_d;
    logic [31:0]     fir_x_q, fir_x_d;
    logic [31:0]     m_data_q, m_data_d;
    logic [TW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic            err_q, err_d;
    logic [15:0]     smp_cnt_q, smp_cnt_d;

    logic fifo_full;
    logic fifo_nempty;
    logic push;
    logic pop;
    logic tmo_hit;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign fifo_full   = (fifo_cnt_q == CW'(FIFO_DEPTH));
    assign fifo_nempty = (fifo_cnt_q != '0);
    assign push        = s_valid & ~fifo_full;
    assign pop         = (state_q == ST_IDLE) & fifo_nempty & fir_idle;
    assign tmo_hit     = (tmo_cnt_q == TW'(TIMEOUT - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pop) state_d = ST_LAUNCH;
            ST_LAUNCH: state_d = ST_WAIT;
            ST_WAIT: begin
                if (fir_done) begin
                    state_d = ST_OUT;
                end else if (tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_OUT:    if (m_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        fir_start = (state_q == ST_LAUNCH);
        m_valid   = (state_q == ST_OUT);
        busy      = (state_q != ST_IDLE);
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        coef_d     = coef_q;
        c_q0_d     = c_q0_q;
        fir_x_d    = fir_x_q;
        m_data_d   = m_data_q;
        tmo_cnt_d  = tmo_cnt_q;
        err_d      = err_q;
        smp_cnt_d  = smp_cnt_q;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = s_data;
            wr_ptr_d             = ptr_inc(wr_ptr_q);
        end
        // Popping only from the registered count keeps a same-cycle push invisible to the pop.
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
            fir_x_d  = fifo_mem_q[rd_ptr_q];
        end
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + CW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - CW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase

        if (cfg_we && (state_q == ST_IDLE) && (32'(cfg_addr) < NTAPS)) begin
            coef_d[cfg_addr] = cfg_data;
        end
        // Reads use the pre-write coefficient, so a colliding write shows up one read later.
        if (c_ce0) begin
            c_q0_d = (32'(c_address0) < NTAPS) ? coef_q[c_address0] : 32'd0;
        end

        if (state_q == ST_LAUNCH) begin
            tmo_cnt_d = '0;
        end else if (state_q == ST_WAIT) begin
            if (fir_done) begin
                m_data_d = fir_return;
            end else if (tmo_hit) begin
                err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end

        if ((state_q == ST_OUT) && m_ready) begin
            smp_cnt_d = smp_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            coef_q     <= '{default: '0};
            c_q0_q     <= '0;
            fir_x_q    <= '0;
            m_data_q   <= '0;
            tmo_cnt_q  <= '0;
            err_q      <= 1'b0;
            smp_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            coef_q     <= coef_d;
            c_q0_q     <= c_q0_d;
            fir_x_q    <= fir_x_d;
            m_data_q   <= m_data_d;
            tmo_cnt_q  <= tmo_cnt_d;
            err_q      <= err_d;
            smp_cnt_q  <= smp_cnt_d;
        end
    end

    // Storage needs no reset; occupancy is governed entirely by the pointers and count.
    always_ff @(posedge ap_clk) begin
        fifo_mem_q <= fifo_mem_d;
    end

    assign s_ready      = ~fifo_full;
    assign m_data       = m_data_q;
    assign fir_x        = fir_x_q;
    assign c_q0         = c_q0_q;
    assign err_timeout  = err_q;
    assign sample_count = smp_cnt_q;

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Directed bench for fir_seq_ctrl: coefficient file, single-sample flow, backpressure, timeout, reset abort.
module tb_fir_seq_ctrl;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        cfg_we;
    logic [3:0]  cfg_addr;
    logic [31:0] cfg_data;
    logic        fir_start;
    logic [31:0] fir_x;
    logic        fir_done;
    logic        fir_idle;
    logic [31:0] fir_return;
    logic [3:0]  c_address0;
    logic        c_ce0;
    logic [31:0] c_q0;
    logic        busy;
    logic        err_timeout;
    logic [15:0] sample_count;

    int          n_vec = 0;
    int          n_err = 0;
    int          launch_cnt = 0;
    int          exp_launch = 0;
    logic [31:0] launch_x = '0;

    always #5 ap_clk = ~ap_clk;

    fir_seq_ctrl dut (
        .ap_clk       (ap_clk),
        .ap_rst       (ap_rst),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .m_data       (m_data),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .fir_start    (fir_start),
        .fir_x        (fir_x),
        .fir_done     (fir_done),
        .fir_idle     (fir_idle),
        .fir_return   (fir_return),
        .c_address0   (c_address0),
        .c_ce0        (c_ce0),
        .c_q0         (c_q0),
        .busy         (busy),
        .err_timeout  (err_timeout),
        .sample_count (sample_count)
    );

    // Launch monitor: counts fir_start cycles and records the operand presented with each.
    always @(negedge ap_clk) begin
        if (fir_start) begin
            launch_cnt = launch_cnt + 1;
            launch_x   = fir_x;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        int n = 0;
        s_data  = d;
        s_valid = 1'b1;
        while (!s_ready && n < 50) begin
            step();
            n++;
        end
        check("push_ready", 32'(s_ready), 32'd1);
        step();
        s_valid = 1'b0;
    endtask

    // Completes one FIR job: waits for its launch, returns x ^ 0xA5A50000, drains the result.
    task automatic serve(input logic [31:0] x);
        int          n = 0;
        logic [31:0] r;
        while (launch_cnt <= exp_launch && n < 40) begin
            step();
            n++;
        end
        check("launch_seen", 32'(launch_cnt > exp_launch), 32'd1);
        exp_launch++;
        check("launch_x", launch_x, x);
        repeat (2) step();
        check("fir_x_hold", fir_x, x);
        r          = x ^ 32'hA5A5_0000;
        fir_return = r;
        fir_done   = 1'b1;
        step();
        fir_done   = 1'b0;
        check("m_valid_set", 32'(m_valid), 32'd1);
        check("m_data", m_data, r);
        step();
        check("m_valid_hold", 32'(m_valid), 32'd1);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("m_valid_clr", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, observed 0x%08h vectors expected completion", n_vec);
        $fatal(1, "watchdog");
    end

    initial begin
        logic x_stable;
        ap_rst     = 1'b1;
        s_data     = '0;
        s_valid    = 1'b0;
        m_ready    = 1'b0;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_data   = '0;
        fir_done   = 1'b0;
        fir_idle   = 1'b1;
        fir_return = '0;
        c_address0 = '0;
        c_ce0      = 1'b0;
        repeat (2) step();
        ap_rst = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_s_ready", 32'(s_ready), 32'd1);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_fir_start", 32'(fir_start), 32'd0);
        check("rst_m_data", m_data, 32'd0);
        check("rst_fir_x", fir_x, 32'd0);
        check("rst_c_q0", c_q0, 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_count", 32'(sample_count), 32'd0);

        c_ce0 = 1'b1; c_address0 = 4'd3;
        step();
        check("coef_rst_val", c_q0, 32'd0);
        c_ce0 = 1'b0;

        for (int k = 0; k < 11; k++) begin
            cfg_we = 1'b1; cfg_addr = 4'(k); cfg_data = 32'(k + 1);
            step();
        end
        cfg_we = 1'b0;

        c_ce0 = 1'b1; c_address0 = 4'd3;
        step();
        check("coef_rd3", c_q0, 32'd4);
        c_address0 = 4'd12;
        step();
        check("coef_rd12", c_q0, 32'd0);
        c_address0 = 4'd10;
        step();
        check("coef_rd10", c_q0, 32'd11);
        c_ce0 = 1'b0; c_address0 = 4'd3;
        step();
        check("coef_hold", c_q0, 32'd11);

        cfg_we = 1'b1; cfg_addr = 4'd5; cfg_data = 32'h0000_00AA;
        c_ce0  = 1'b1; c_address0 = 4'd5;
        step();
        cfg_we = 1'b0;
        check("coef_rw_old", c_q0, 32'd6);
        step();
        check("coef_rw_new", c_q0, 32'h0000_00AA);
        c_ce0 = 1'b0;

        // Single sample with cycle-exact launch timing and a 60-cycle FIR.
        push(32'd5);
        check("lat_t1_start", 32'(fir_start), 32'd0);
        step();
        check("lat_t2_start", 32'(fir_start), 32'd1);
        check("lat_t2_x", fir_x, 32'd5);
        check("lat_t2_busy", 32'(busy), 32'd1);
        step();
        check("start_pulse_end", 32'(fir_start), 32'd0);
        exp_launch++;
        x_stable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cfg_we = (i == 10); cfg_addr = 4'd2; cfg_data = 32'h0000_FFFF;
            step();
            if (fir_x !== 32'd5 || fir_start !== 1'b0 || m_valid !== 1'b0) x_stable = 1'b0;
        end
        cfg_we = 1'b0;
        check("wait_stable", 32'(x_stable), 32'd1);
        fir_return = 32'h0000_1234; fir_done = 1'b1;
        step();
        fir_done = 1'b0; fir_return = '0;
        check("out_valid", 32'(m_valid), 32'd1);
        check("out_data", m_data, 32'h0000_1234);
        repeat (3) step();
        check("out_valid_hold", 32'(m_valid), 32'd1);
        check("out_data_hold", m_data, 32'h0000_1234);
        check("out_x_hold", fir_x, 32'd5);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("out_done_valid", 32'(m_valid), 32'd0);
        check("out_done_busy", 32'(busy), 32'd0);
        check("count_1", 32'(sample_count), 32'd1);

        fir_done = 1'b1;
        step();
        fir_done = 1'b0;
        check("stray_done_busy", 32'(busy), 32'd0);
        check("stray_done_valid", 32'(m_valid), 32'd0);
        c_ce0 = 1'b1; c_address0 = 4'd2;
        step();
        c_ce0 = 1'b0;
        check("coef_wait_wr", c_q0, 32'd3);

        // Backpressure: five accepted (one in flight + four queued), sixth refused.
        for (int i = 0; i < 5; i++) push(32'h10 + 32'(i));
        check("full_s_ready", 32'(s_ready), 32'd0);
        s_valid = 1'b1; s_data = 32'h15;
        step();
        check("full_s_ready_hold", 32'(s_ready), 32'd0);
        s_valid = 1'b0;
        serve(32'h10);
        push(32'h15);
        for (int i = 1; i < 6; i++) serve(32'h10 + 32'(i));
        check("count_7", 32'(sample_count), 32'd7);

        // Timeout: no fir_done for 255 WAIT cycles.
        push(32'h77);
        step();
        check("tmo_launch", 32'(fir_start), 32'd1);
        check("tmo_x", fir_x, 32'h77);
        exp_launch++;
        repeat (255) step();
        check("tmo_pre_busy", 32'(busy), 32'd1);
        check("tmo_pre_err", 32'(err_timeout), 32'd0);
        step();
        check("tmo_err", 32'(err_timeout), 32'd1);
        check("tmo_idle", 32'(busy), 32'd0);
        check("tmo_no_valid", 32'(m_valid), 32'd0);
        push(32'h88);
        serve(32'h88);
        check("tmo_sticky", 32'(err_timeout), 32'd1);
        check("count_8", 32'(sample_count), 32'd8);

        // Reset in WAIT, then a late fir_done.
        push(32'h99);
        repeat (3) step();
        exp_launch++;
        check("rst_pre_busy", 32'(busy), 32'd1);
        ap_rst = 1'b1;
        step();
        ap_rst = 1'b0;
        fir_return = 32'h5555; fir_done = 1'b1;
        step();
        fir_done = 1'b0;
        check("abort_valid", 32'(m_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_m_data", m_data, 32'd0);
        check("abort_fir_x", fir_x, 32'd0);
        check("abort_err", 32'(err_timeout), 32'd0);
        check("abort_count", 32'(sample_count), 32'd0);
        check("abort_c_q0", c_q0, 32'd0);
        check("abort_start", 32'(fir_start), 32'd0);
        check("abort_s_ready", 32'(s_ready), 32'd1);
        c_ce0 = 1'b1; c_address0 = 4'd3;
        step();
        c_ce0 = 1'b0;
        check("abort_coef", c_q0, 32'd0);
        repeat (3) step();
        check("abort_quiet", 32'(m_valid | busy), 32'd0);
        check("launch_pulses", 32'(launch_cnt), 32'(exp_launch));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
